// File: rtl/cpu_run_ctrl.sv
// Run controller for CPU bring-up: pulses the CPU reset, re-runs the program NUM_RUNS times,
// detects halt from the PC/instruction taps, enforces a per-run timeout and reports the
// cycle counts of the first and last runs.
module cpu_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned NUM_RUNS     = 2,
  parameter int unsigned MAX_CYCLES   = 600,
  parameter logic [31:0] HALT_INSN    = 32'h0000006F,
  parameter int unsigned HALT_REPEAT  = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [31:0]      pc_debug,
  input  logic [31:0]      instruction_debug,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [7:0]       run_idx,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] first_cycles,
  output logic [CNT_W-1:0] last_cycles,
  output logic [31:0]      final_pc
);

  localparam int unsigned RstW = $clog2(RESET_CYCLES + 1);
  localparam int unsigned StrW = $clog2(HALT_REPEAT + 1);

  localparam logic [RstW-1:0]  RstLoad   = RstW'(RESET_CYCLES);
  localparam logic [StrW-1:0]  StrTarget = StrW'(HALT_REPEAT);
  localparam logic [CNT_W-1:0] CntLast   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [7:0]       RunLast   = 8'(NUM_RUNS - 1);

  typedef enum logic [1:0] {StIdle, StRst, StRun, StDone} state_e;

  state_e            st_q;
  logic [RstW-1:0]   rst_cnt_q;
  logic [StrW-1:0]   streak_q;
  logic [31:0]       prev_pc_q;

  logic [CNT_W-1:0]  cnt_inc;
  logic              streak_hit;
  logic [StrW-1:0]   streak_nxt;
  logic              halt_hit;
  logic              tmo_hit;

  // Halt-streak and timeout decode for the current RUN cycle; the first RUN cycle never counts
  // because prev_pc_q still holds a PC sampled while the CPU was in reset.
  always_comb begin
    cnt_inc    = cycle_cnt + CNT_W'(1);
    streak_hit = (instruction_debug == HALT_INSN) && (pc_debug == prev_pc_q) &&
                 (cycle_cnt != '0);
    streak_nxt = streak_hit ? (streak_q + StrW'(1)) : '0;
    halt_hit   = streak_hit && (streak_nxt == StrTarget);
    tmo_hit    = (cycle_cnt == CntLast);
  end

  // Sequencing FSM; every output is a register updated alongside the state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st_q         <= StIdle;
      rst_cnt_q    <= '0;
      streak_q     <= '0;
      prev_pc_q    <= '0;
      cpu_reset    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      run_idx      <= '0;
      cycle_cnt    <= '0;
      first_cycles <= '0;
      last_cycles  <= '0;
      final_pc     <= '0;
    end else begin
      prev_pc_q <= pc_debug;
      unique case (st_q)
        StIdle, StDone: begin
          if (start) begin
            st_q         <= StRst;
            rst_cnt_q    <= RstLoad;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            run_idx      <= '0;
            first_cycles <= '0;
            last_cycles  <= '0;
            final_pc     <= '0;
          end
        end
        StRst: begin
          if (rst_cnt_q == RstW'(1)) begin
            st_q      <= StRun;
            cpu_reset <= 1'b0;
            cycle_cnt <= '0;
            streak_q  <= '0;
          end else begin
            rst_cnt_q <= rst_cnt_q - RstW'(1);
          end
        end
        StRun: begin
          cycle_cnt <= cnt_inc;
          streak_q  <= streak_nxt;
          // Halt is tested first so it wins a tie with the timeout.
          if (halt_hit) begin
            last_cycles <= cnt_inc;
            if (run_idx == '0) first_cycles <= cnt_inc;
            cpu_reset <= 1'b1;
            if (run_idx < RunLast) begin
              run_idx   <= run_idx + 8'd1;
              rst_cnt_q <= RstLoad;
              st_q      <= StRst;
            end else begin
              final_pc <= pc_debug;
              pass     <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
              st_q     <= StDone;
            end
          end else if (tmo_hit) begin
            timeout   <= 1'b1;
            final_pc  <= pc_debug;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            st_q      <= StDone;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

endmodule
